// File: rtl/mem_responder.sv
// mem_responder: byte-serial RAM/IO responder on the far side of the external memory bus.
// Optional RX FIFO and RX status bit are built only when MEM_RESPONDER_RX_EN is defined.
module mem_responder #(
    parameter int ADDR_WIDTH     = 17,
    parameter int FIFO_DEPTH_LOG = 3,
    parameter int FULL_MARGIN    = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        tx_overflow,
    output logic        sim_halt
);
    localparam int CW = FIFO_DEPTH_LOG + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_THRESH = CW'(DEPTH - FULL_MARGIN);
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [FIFO_DEPTH_LOG-1:0] PTR_ONE = 1;
    localparam logic [17:0] IO_DATA = 18'h30000;
    localparam logic [17:0] IO_STAT = 18'h30004;

    logic [7:0] ram [0:(1<<ADDR_WIDTH)-1];
    logic [7:0] tx_mem [DEPTH];

    logic                  is_io, bus_rd, bus_wr, ram_we;
    logic                  tx_push_req, tx_push, tx_pop, halt_wr;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [17:0]           io_addr;
    logic                  rx_nonempty;
    logic [7:0]            rx_head;
    logic [7:0]            tx_head_d;
    logic                  unused_hi;

    logic [FIFO_DEPTH_LOG-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
    logic [CW-1:0]             tx_count_q, tx_count_d;
    logic [7:0]                tx_data_q, tx_data_d, mem_rdata_q, mem_rdata_d;
    logic                      tx_valid_q, tx_valid_d, io_buffer_full_q, io_buffer_full_d;
    logic                      tx_overflow_q, tx_overflow_d, sim_halt_q, sim_halt_d;

    assign io_addr     = mem_a[17:0];
    assign ram_addr    = mem_a[ADDR_WIDTH-1:0];
    assign unused_hi   = ^mem_a[31:18];
    assign is_io       = (io_addr[17:16] == 2'b11);
    assign bus_rd      = rdy_in && !mem_wr;
    assign bus_wr      = rdy_in && mem_wr;
    assign ram_we      = bus_wr && !is_io;
    assign tx_push_req = bus_wr && is_io && (io_addr == IO_DATA);
    assign tx_push     = tx_push_req && (tx_count_q != FULL_CNT);
    assign tx_pop      = tx_valid_q && tx_ready;
    assign halt_wr     = bus_wr && is_io && (io_addr == IO_STAT);

    assign mem_rdata      = mem_rdata_q;
    assign io_buffer_full = io_buffer_full_q;
    assign tx_data        = tx_data_q;
    assign tx_valid       = tx_valid_q;
    assign tx_overflow    = tx_overflow_q;
    assign sim_halt       = sim_halt_q;

    always_ff @(posedge clk_in) begin
        if (ram_we) ram[ram_addr] <= mem_wdata;
    end

    always_ff @(posedge clk_in) begin
        if (tx_push) tx_mem[tx_wr_ptr_q] <= mem_wdata;
    end

    always_comb begin
        mem_rdata_d = mem_rdata_q;
        if (bus_rd) begin
            if (!is_io)                   mem_rdata_d = ram[ram_addr];
            else if (io_addr == IO_DATA)  mem_rdata_d = rx_nonempty ? rx_head : 8'h00;
            else if (io_addr == IO_STAT)  mem_rdata_d = {7'b0, rx_nonempty};
            else                          mem_rdata_d = 8'h00;
        end

        tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + PTR_ONE : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + PTR_ONE : tx_rd_ptr_q;
        unique case ({tx_push, tx_pop})
            2'b10:   tx_count_d = tx_count_q + CNT_ONE;
            2'b01:   tx_count_d = tx_count_q - CNT_ONE;
            default: tx_count_d = tx_count_q;
        endcase

        // A byte pushed into a FIFO that is (or becomes) empty is the new head before it lands in tx_mem.
        tx_head_d = (tx_push && (tx_wr_ptr_q == tx_rd_ptr_d)) ? mem_wdata : tx_mem[tx_rd_ptr_d];
        tx_data_d = (tx_count_d != '0) ? tx_head_d : 8'h00;
        tx_valid_d = (tx_count_d != '0);
        io_buffer_full_d = (tx_count_d >= FULL_THRESH);
        tx_overflow_d = tx_overflow_q || (tx_push_req && (tx_count_q == FULL_CNT));
        sim_halt_d = sim_halt_q || halt_wr;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tx_wr_ptr_q      <= '0;
            tx_rd_ptr_q      <= '0;
            tx_count_q       <= '0;
            tx_data_q        <= 8'h00;
            tx_valid_q       <= 1'b0;
            io_buffer_full_q <= 1'b0;
            tx_overflow_q    <= 1'b0;
            sim_halt_q       <= 1'b0;
            mem_rdata_q      <= 8'h00;
        end else begin
            tx_wr_ptr_q      <= tx_wr_ptr_d;
            tx_rd_ptr_q      <= tx_rd_ptr_d;
            tx_count_q       <= tx_count_d;
            tx_data_q        <= tx_data_d;
            tx_valid_q       <= tx_valid_d;
            io_buffer_full_q <= io_buffer_full_d;
            tx_overflow_q    <= tx_overflow_d;
            sim_halt_q       <= sim_halt_d;
            mem_rdata_q      <= mem_rdata_d;
        end
    end

`ifdef MEM_RESPONDER_RX_EN
    logic [7:0]                rx_mem [DEPTH];
    logic [FIFO_DEPTH_LOG-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CW-1:0]             rx_count_q, rx_count_d;
    logic                      rx_push, rx_pop;

    assign rx_nonempty = (rx_count_q != '0);
    assign rx_head     = rx_mem[rx_rd_ptr_q];
    assign rx_push     = rx_valid && (rx_count_q != FULL_CNT);
    assign rx_pop      = bus_rd && is_io && (io_addr == IO_DATA) && rx_nonempty;

    always_ff @(posedge clk_in) begin
        if (rx_push) rx_mem[rx_wr_ptr_q] <= rx_data;
    end

    always_comb begin
        rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + PTR_ONE : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + PTR_ONE : rx_rd_ptr_q;
        unique case ({rx_push, rx_pop})
            2'b10:   rx_count_d = rx_count_q + CNT_ONE;
            2'b01:   rx_count_d = rx_count_q - CNT_ONE;
            default: rx_count_d = rx_count_q;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
        end else begin
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_count_q  <= rx_count_d;
        end
    end
`else
    logic unused_rx;

    assign rx_nonempty = 1'b0;
    assign rx_head     = 8'h00;
    assign unused_rx   = ^{rx_data, rx_valid};
`endif

endmodule

// File: doc/mem_responder.md
# mem_responder

Byte-serial memory/IO responder sitting on the far side of the CPU's external memory bus. It answers `mem_a`/`mem_wr` accesses issued by the memory controller with one-cycle-latency byte reads from on-chip RAM. It decodes the IO window to a UART TX FIFO, an RX FIFO and a halt register. It produces the `io_buffer_full` back-pressure the controller consumes.

## Interface
Reset: asynchronous, active-high, `rst_in`; one clock, `clk_in`.

Parameters:
- `ADDR_WIDTH`, 17: RAM address bits; RAM holds 2^ADDR_WIDTH bytes.
- `FIFO_DEPTH_LOG`, 3: TX/RX FIFO depth = 2^FIFO_DEPTH_LOG entries.
- `FULL_MARGIN`, 2: free TX slots at which `io_buffer_full` asserts.

Ports:
- `clk_in` in 1: system clock.
- `rst_in` in 1: async active-high reset.
- `rdy_in` in 1: bus accesses ignored when low.
- `mem_a` in 32: byte address; bits [17:0] decoded.
- `mem_wr` in 1: 1 = write, 0 = read.
- `mem_wdata` in 8: write byte (controller's `mem_dout`).
- `mem_rdata` out 8: read byte (controller's `mem_din`), registered.
- `io_buffer_full` out 1: TX FIFO nearly full, registered.
- `tx_data` out 8: TX FIFO head.
- `tx_valid` out 1: TX FIFO non-empty.
- `tx_ready` in 1: UART accepts head this cycle.
- `rx_data` in 8, `rx_valid` in 1: byte from UART receiver.
- `tx_overflow` out 1: sticky, TX write dropped while full.
- `sim_halt` out 1: sticky, set by halt write.

## Operation
- Decode: IO iff `mem_a[17:16] == 2'b11`; else RAM at `mem_a[ADDR_WIDTH-1:0]`.
- RAM write: `rdy_in && mem_wr && !io` → `ram[addr] <= mem_wdata`.
- RAM read: `rdy_in && !mem_wr && !io` → `mem_rdata <= ram[addr]`; a write in cycle N is visible to a read issued in cycle N+1.
- IO read 0x30000: RX FIFO non-empty → `mem_rdata <= head`, pop; empty → `mem_rdata <= 8'h00`, no pop.
- IO read 0x30004: `mem_rdata <= {7'b0, rx_nonempty}`.
- IO write 0x30000: push `mem_wdata` into TX FIFO; if full, drop and set `tx_overflow`.
- IO write 0x30004: set `sim_halt`.
- Other IO addresses: reads return 0x00; writes have no effect.
- Write cycles and `rdy_in` low: `mem_rdata` holds its previous value.
- TX drain independent of `rdy_in`: pop when `tx_valid && tx_ready`.
- RX push: when `rx_valid` is high and the RX FIFO is not full; otherwise the byte is dropped.
- FIFOs: circular, pointers of FIFO_DEPTH_LOG bits wrap modulo depth, count of FIFO_DEPTH_LOG+1 bits. Simultaneous push and pop leaves count unchanged; push-when-full is refused even when a pop occurs the same cycle.
- `io_buffer_full <= (tx_count_next >= 2^FIFO_DEPTH_LOG - FULL_MARGIN)`; the margin covers the controller's one-cycle sampling lag.

## Timing
- Read latency exactly 1 cycle: address in cycle N, data valid on `mem_rdata` in cycle N+1; back-to-back reads yield one byte per cycle.
- Write takes effect at the clock edge of the issuing cycle.
- `io_buffer_full`, `tx_valid` and `tx_data` update the cycle after the count changes.
- Reset values: `mem_rdata` 0x00, `io_buffer_full` 0, `tx_valid` 0, `tx_data` 0x00, `tx_overflow` 0, `sim_halt` 0; FIFOs empty; RAM contents not reset.
- Reset mid-burst: everything aborts immediately; the first access after release is served normally.

## Configuration
- `MEM_RESPONDER_RX_EN` defined: RX FIFO, the `rx_*` path and the 0x30004 status bit are built as described.
- Not defined: no RX FIFO; `rx_data`/`rx_valid` are ignored; reads of 0x30000 and 0x30004 return 0x00.

## Test plan
- RAM burst: write 0x11,0x22,0x33,0x44 to 0x100..0x103 on consecutive cycles, then read the same addresses on 4 consecutive cycles → `mem_rdata` = 0x11,0x22,0x33,0x44 on cycles N+1..N+4.
- TX back-pressure: `tx_ready`=0, depth 8, margin 2; write 6 bytes to 0x30000 → `io_buffer_full` 1 the cycle after the 6th push. A 9th write sets `tx_overflow`; raising `tx_ready` drains the first 8 bytes in order.
- RX path (macro defined): pulse `rx_valid` with 0x5A, then read 0x30004 → 0x01. Read 0x30000 → 0x5A; read 0x30000 again → 0x00.
- Simultaneous push/pop: TX count 3 with `tx_ready`=1 while writing 0x30000 → count stays 3, order preserved.
- `rdy_in`=0 during a RAM write to 0x200 (0xEE) → RAM unchanged; a later read of 0x200 returns the old value, and `mem_rdata` holds while `rdy_in` is low.
- Async reset asserted between clock edges mid-stream → all outputs 0 before the next edge; write to 0x30004 after release → `sim_halt`=1.
